multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control unit for the small RISC core: sequences the program counter, instruction register, register file, ALU and data memory through FETCH/DECODE/EXEC/MEM/WB for the ADD, SUB, ADDI, SW, NOP and HALT instructions. It sits between instruction memory and the datapath, drives every datapath enable, and waits on a data-memory acknowledge for stores. It replaces free-running PC stepping with explicit per-instruction sequencing.

## Interface
- PC_W, 3, program counter width (8-instruction program space)
- WAIT_MAX, 7, cycles to wait for mem_ack before flagging a bus error
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  level; leaves IDLE/HALTED and begins fetching at pc = 0
- opcode  in  4  instruction-memory opcode field, valid while in FETCH
- mem_ack  in  1  data-memory write acknowledge (single-cycle pulse)
- pc  out  PC_W  current instruction address
- ir_load  out  1  latch the instruction register
- alu_op  out  4  ALU operation (equals latched opcode for ADD/SUB/ADDI, else 0000)
- alu_src_imm  out  1  ALU B operand = immediate (ADDI)
- reg_we  out  1  register-file write enable
- mem_we  out  1  data-memory write request (held until ack or timeout)
- busy  out  1  not in IDLE or HALTED
- halted  out  1  in HALTED
- err  out  1  sticky: illegal opcode or store timeout
- retired  out  8  retired-instruction count (only with CTRL_PERF_EN)

## Operation
- Opcodes: 0000 NOP, 0010 ADD, 0011 SUB, 0100 ADDI, 0101 SW, 1111 HALT; any other opcode is illegal.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED.
- IDLE: start=1 -> FETCH with pc=0, err cleared.
- FETCH: ir_load=1 for one cycle, opcode latched -> DECODE.
- DECODE: NOP -> FETCH with pc+1. HALT -> HALTED. Illegal -> err=1, then treated as NOP. ADD/SUB/ADDI/SW -> EXEC.
- EXEC: alu_op driven, alu_src_imm=1 for ADDI and SW (address = base + imm). ALU ops -> WB. SW -> MEM.
- WB: reg_we=1 for exactly one cycle, pc+1 -> FETCH.
- MEM: mem_we held high. mem_ack -> pc+1 -> FETCH. Wait counter reaching WAIT_MAX without ack sets err, drops mem_we, and advances pc+1 -> FETCH.
- HALTED: holds pc. start=1 -> FETCH with pc=0. start=0 stays.
- pc wraps modulo 2^PC_W (7 -> 0). No carry out and no error on wrap.
- alu_op, alu_src_imm, reg_we and mem_we are 0 in every state not listed above.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, pc=0, all enables 0, busy=0, halted=0, err=0, retired=0.
- All outputs are registered, or decoded from state and the latched opcode only. No input-to-output combinational path.
- Cycles per instruction: NOP/illegal 2 (FETCH, DECODE). ALU 4 (FETCH, DECODE, EXEC, WB). SW 3+n, where n is the MEM cycles up to and including the ack. HALT 2.
- mem_ack in the first MEM cycle gives n=1. mem_ack outside MEM is ignored.
- pc updates on the clock edge leaving WB, MEM, or a NOP/illegal DECODE.
- Timeout: err asserts on the edge after the WAIT_MAX-th MEM cycle without an ack.
- rst asserted mid-instruction aborts it immediately: mem_we and reg_we drop asynchronously, no partial write is counted.
- start is sampled only in IDLE and HALTED and ignored elsewhere.

## Configuration
- CTRL_PERF_EN defined:
  - retired increments once per instruction completion (WB exit, MEM exit, NOP/illegal DECODE exit; HALT counts on entry to HALTED).
  - Saturates at 255 and clears on reset or on start.
- CTRL_PERF_EN undefined: the retired port is still present, tied to 0, with no counter logic.

## Structure
- Package ctrl_pkg holds:
  - the state enum
  - opcode localparams (OP_NOP, OP_ADD, OP_SUB, OP_ADDI, OP_SW, OP_HALT)
  - an is_legal function
- No sub-module. The FSM, pc register and wait counter live in one module.

## Test plan
- Program ADD, SUB, ADDI, NOP after start pulse -> ir_load at cycles 1,5,9,13; reg_we one cycle each in WB; pc 0->1->2->3->4; alu_src_imm only for ADDI.
- SW with mem_ack on the 3rd MEM cycle -> mem_we high 3 cycles, then pc+1, err=0, 6-cycle instruction.
- SW with mem_ack never asserted -> err=1 after 7 MEM cycles, mem_we drops, pc advances.
- Opcode 1010 -> err=1, no reg_we/mem_we, pc+1 after 2 cycles. Eight NOPs from pc=0 -> pc wraps 7->0.
- HALT -> halted=1, pc frozen for 20 cycles; start=1 -> FETCH at pc=0, halted=0.
- rst low during MEM with mem_we=1 -> mem_we=0 immediately, state IDLE, pc=0. With CTRL_PERF_EN, the four-instruction program gives retired=4, and 300 NOPs give retired=255.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - state encoding, opcode values and opcode legality check for multicycle_ctrl
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALTED = 3'd6
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_SW   = 4'b0101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      OP_NOP, OP_ADD, OP_SUB, OP_ADDI, OP_SW, OP_HALT: is_legal = 1'b1;
      default:                                         is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - FETCH/DECODE/EXEC/MEM/WB sequencer for the small RISC core
// CTRL_PERF_EN adds the saturating retired-instruction counter; otherwise retired is tied to 0.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int PC_W     = 3,
  parameter int WAIT_MAX = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      opcode,
  input  logic            mem_ack,
  output logic [PC_W-1:0] pc,
  output logic            ir_load,
  output logic [3:0]      alu_op,
  output logic            alu_src_imm,
  output logic            reg_we,
  output logic            mem_we,
  output logic            busy,
  output logic            halted,
  output logic            err,
  output logic [7:0]      retired
);

  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [3:0]      ir_q, ir_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            err_q, err_d;

  logic alu_ir;
  logic needs_exec;
  logic mem_timeout;

  assign alu_ir      = (ir_q == OP_ADD) || (ir_q == OP_SUB) || (ir_q == OP_ADDI);
  assign needs_exec  = alu_ir || (ir_q == OP_SW);
  assign mem_timeout = (wait_q == WAIT_LAST);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    wait_d  = wait_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          if (state_q == S_IDLE) err_d = 1'b0;
        end
      end
      S_FETCH: begin
        ir_d    = opcode;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (ir_q == OP_HALT) begin
          state_d = S_HALTED;
        end else if (needs_exec) begin
          state_d = S_EXEC;
        end else begin
          // illegal opcodes raise err and then retire exactly like a NOP
          if (!is_legal(ir_q)) err_d = 1'b1;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        wait_d  = '0;
        state_d = (ir_q == OP_SW) ? S_MEM : S_WB;
      end
      S_WB: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = S_FETCH;
      end
      S_MEM: begin
        if (mem_ack || mem_timeout) begin
          if (!mem_ack) err_d = 1'b1;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_FETCH;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= OP_NOP;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // enables decode from state only, so an async reset drops them at once
  assign pc          = pc_q;
  assign ir_load     = (state_q == S_FETCH);
  assign alu_op      = ((state_q == S_EXEC) && alu_ir) ? ir_q : 4'b0000;
  assign alu_src_imm = (state_q == S_EXEC) && ((ir_q == OP_ADDI) || (ir_q == OP_SW));
  assign reg_we      = (state_q == S_WB);
  assign mem_we      = (state_q == S_MEM);
  assign busy        = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign halted      = (state_q == S_HALTED);
  assign err         = err_q;

`ifdef CTRL_PERF_EN
  logic [7:0] retired_q, retired_d;
  logic       restart;
  logic       retire;

  assign restart = ((state_q == S_IDLE) || (state_q == S_HALTED)) && start;
  // HALT retires on its way into HALTED; SW on ack or timeout
  assign retire  = (state_q == S_WB)
                || ((state_q == S_MEM) && (mem_ack || mem_timeout))
                || ((state_q == S_DECODE) && !needs_exec);

  always_comb begin
    retired_d = retired_q;
    if (restart) begin
      retired_d = 8'h00;
    end else if (retire && (retired_q != 8'hFF)) begin
      retired_d = retired_q + 8'h01;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_q <= 8'h00;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
`else
  assign retired = 8'h00;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl with a per-instruction reference model
module tb_multicycle_ctrl;

  localparam int PC_W     = 3;
  localparam int WAIT_MAX = 7;
  localparam int NPC      = 1 << PC_W;
`ifdef CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [3:0]      opcode = 4'h0;
  logic            mem_ack = 1'b0;
  logic [PC_W-1:0] pc;
  logic            ir_load;
  logic [3:0]      alu_op;
  logic            alu_src_imm;
  logic            reg_we;
  logic            mem_we;
  logic            busy;
  logic            halted;
  logic            err;
  logic [7:0]      retired;

  multicycle_ctrl #(.PC_W(PC_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .mem_ack(mem_ack),
    .pc(pc), .ir_load(ir_load), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
    .reg_we(reg_we), .mem_we(mem_we), .busy(busy), .halted(halted),
    .err(err), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc;
    int cycles;
    int reg_n;
    int mem_n;
    int alu_n;
    int alu_op;
    int imm_n;
    int busy_n;
    int err;
    int pc_after;
    int halted_after;
    int retired;
  } rec_t;

  rec_t       exp_q[$];
  logic [3:0] op_q[$];
  int         ack_q[$];
  int         n_checks = 0;
  int         n_pass = 0;
  int         m_pc = 0;
  int         m_err = 0;
  int         m_ret = 0;
  bit         want_start = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // reference model: one record of observable behaviour per instruction
  task automatic issue(input logic [3:0] op, input int ack_at);
    rec_t r;
    int   n;
    r = '{default: 0};
    r.pc = m_pc;
    if (op == 4'h2 || op == 4'h3 || op == 4'h4) begin
      r.cycles = 4; r.reg_n = 1; r.alu_n = 1; r.alu_op = int'(op);
      r.imm_n = (op == 4'h4) ? 1 : 0;
      m_pc = (m_pc + 1) % NPC;
    end else if (op == 4'h5) begin
      if (ack_at >= 1 && ack_at <= WAIT_MAX) n = ack_at;
      else begin n = WAIT_MAX; m_err = 1; end
      r.cycles = 3 + n; r.mem_n = n; r.imm_n = 1;
      m_pc = (m_pc + 1) % NPC;
      ack_q.push_back(ack_at);
    end else if (op == 4'hF) begin
      r.cycles = 2; r.halted_after = 1;
    end else begin
      r.cycles = 2;
      if (op != 4'h0) m_err = 1;
      m_pc = (m_pc + 1) % NPC;
    end
    r.busy_n = r.cycles;
    m_ret = (m_ret < 255) ? m_ret + 1 : 255;
    r.err = m_err;
    r.pc_after = m_pc;
    r.retired = PERF ? m_ret : 0;
    exp_q.push_back(r);
    op_q.push_back(op);
  endtask

  function automatic logic [3:0] rand_op();
    int k;
    logic [3:0] v;
    k = $urandom_range(0, 9);
    case (k)
      0, 1:    v = 4'h0;
      2:       v = 4'h2;
      3:       v = 4'h3;
      4:       v = 4'h4;
      5, 6:    v = 4'h5;
      default: begin
        v = 4'($urandom_range(0, 14));
        while (v == 4'h0 || v == 4'h2 || v == 4'h3 || v == 4'h4 || v == 4'h5)
          v = 4'($urandom_range(0, 14));
      end
    endcase
    return v;
  endfunction

  task automatic begin_stream();
    m_pc = 0;
    m_ret = 0;
  endtask

  task automatic go();
    int t;
    t = 0;
    want_start = 1'b1;
    while (!busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    want_start = 1'b0;
    if (!busy) begin
      n_checks++;
      $display("FAIL start_timeout: got busy=0 expected busy=1");
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!(exp_q.size() == 0 && halted) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) begin
      n_checks++;
      $display("FAIL stream_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    op_q.delete();
    ack_q.delete();
    exp_q.delete();
    m_pc = 0; m_err = 0; m_ret = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // instruction memory, data-memory responder and start driver
  initial begin : driver
    int mem_cnt;
    int cur_ack;
    bit prev_we;
    mem_cnt = 0; cur_ack = 0; prev_we = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        start = 1'b0; mem_ack = 1'b0; opcode = 4'h0; prev_we = 1'b0;
      end else begin
        start = busy ? ($urandom_range(0, 7) == 0) : want_start;
        if (ir_load) opcode = (op_q.size() > 0) ? op_q.pop_front() : 4'hF;
        else         opcode = 4'($urandom_range(0, 15));
        if (mem_we) begin
          if (!prev_we) begin
            mem_cnt = 1;
            cur_ack = (ack_q.size() > 0) ? ack_q.pop_front() : 0;
          end else begin
            mem_cnt++;
          end
          mem_ack = (mem_cnt == cur_ack);
        end else begin
          mem_ack = ($urandom_range(0, 5) == 0);
        end
        prev_we = mem_we;
      end
    end
  end

  initial begin : monitor
    bit   open;
    bit   in_halt;
    bit   hold_bad;
    int   halt_pc;
    rec_t o;
    rec_t e;
    open = 1'b0; in_halt = 1'b0; hold_bad = 1'b0; halt_pc = 0;
    o = '{default: 0};
    forever begin
      @(negedge clk);
      if (!rst) begin
        open = 1'b0; in_halt = 1'b0; hold_bad = 1'b0;
      end else begin
        if (open && (ir_load || halted || !busy)) begin
          open = 1'b0;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_instr: got fetch at pc %0d expected none", o.pc);
          end else begin
            e = exp_q.pop_front();
            chk("fetch_pc", o.pc, e.pc);
            chk("cycles", o.cycles, e.cycles);
            chk("reg_we_cycles", o.reg_n, e.reg_n);
            chk("mem_we_cycles", o.mem_n, e.mem_n);
            chk("alu_op_cycles", o.alu_n, e.alu_n);
            chk("alu_op", o.alu_op, e.alu_op);
            chk("alu_src_imm_cycles", o.imm_n, e.imm_n);
            chk("busy_cycles", o.busy_n, e.busy_n);
            chk("err_after", int'(err), e.err);
            chk("pc_after", int'(pc), e.pc_after);
            chk("halted_after", int'(halted), e.halted_after);
            chk("retired_after", int'(retired), e.retired);
          end
        end
        if (halted) begin
          if (!in_halt) begin
            in_halt = 1'b1; hold_bad = 1'b0; halt_pc = int'(pc);
          end else if (int'(pc) != halt_pc) begin
            hold_bad = 1'b1;
          end
        end
        if (ir_load) begin
          if (in_halt) begin
            chk("halt_hold_pc", int'(hold_bad), 0);
            in_halt = 1'b0;
          end
          open = 1'b1;
          o = '{default: 0};
          o.pc = int'(pc);
        end
        if (open) begin
          o.cycles++;
          o.reg_n  += int'(reg_we);
          o.mem_n  += int'(mem_we);
          o.imm_n  += int'(alu_src_imm);
          o.busy_n += int'(busy);
          if (alu_op != 4'h0) begin
            o.alu_n++;
            o.alu_op = int'(alu_op);
          end
        end
      end
    end
  end

  initial begin : stim
    int t;
    #1 rst = 1'b0;
    #2;
    chk("rst_pc", int'(pc), 0);
    chk("rst_ir_load", int'(ir_load), 0);
    chk("rst_alu_op", int'(alu_op), 0);
    chk("rst_alu_src_imm", int'(alu_src_imm), 0);
    chk("rst_reg_we", int'(reg_we), 0);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_retired", int'(retired), 0);
    do_reset();

    begin_stream();
    issue(4'h2, 0); issue(4'h3, 0); issue(4'h4, 0); issue(4'h0, 0); issue(4'hF, 0);
    go(); wait_done();

    begin_stream();
    issue(4'h5, 3); issue(4'h5, 1); issue(4'h5, WAIT_MAX); issue(4'hF, 0);
    go(); wait_done();

    begin_stream();
    for (int i = 0; i < 8; i++) issue(4'h0, 0);
    issue(4'hF, 0);
    go(); wait_done();

    begin_stream();
    for (int i = 0; i < 300; i++) issue(4'h0, 0);
    issue(4'hF, 0);
    go(); wait_done();

    begin_stream();
    issue(4'h5, 0); issue(4'hF, 0);
    go(); wait_done();

    do_reset();
    begin_stream();
    issue(4'hA, 0); issue(4'h2, 0); issue(4'hF, 0);
    go(); wait_done();

    do_reset();
    begin_stream();
    issue(4'h0, 0); issue(4'h0, 0);
    op_q.push_back(4'h5);
    ack_q.push_back(0);
    go();
    t = 0;
    while (!mem_we && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("abort_mem_we_seen", int'(mem_we), 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_mem_we", int'(mem_we), 0);
    chk("abort_reg_we", int'(reg_we), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_halted", int'(halted), 0);
    chk("abort_pc", int'(pc), 0);
    chk("abort_retired", int'(retired), 0);
    do_reset();

    for (int s = 0; s < 6; s++) begin
      int n;
      begin_stream();
      n = $urandom_range(4, 16);
      for (int i = 0; i < n; i++) issue(rand_op(), $urandom_range(0, 9));
      issue(4'hF, 0);
      go(); wait_done();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
